// File: rtl/seradd_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Optional build macro: SERADD_CLK_GATE_EN (see seradd_sequencer).
package seradd_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LAT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAKE,
    ST_ISSUE,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Cycle (Ack = 0) on which Done is high; the gated build spends one extra cycle in WAKE.
  function automatic int done_cycle(input int width, input int lat, input bit gated);
    return (gated ? 2 : 1) + width * (lat + 1);
  endfunction

endpackage

// File: rtl/seradd_opshift.sv
// Operand pair shift register (LSB first) and result assembly register.
// Shift and bit-write share one strobe so the LSBs always match the bit index.
module seradd_opshift
  import seradd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             a_lsb,
  output logic             b_lsb,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic             wr_bit,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      sh_a <= '0;
      sh_b <= '0;
      acc  <= '0;
    end else if (load) begin
      sh_a <= op_a;
      sh_b <= op_b;
      acc  <= '0;
    end else begin
      if (shift) begin
        sh_a <= sh_a >> 1;
        sh_b <= sh_b >> 1;
      end
      if (wr_en) acc[wr_idx] <= wr_bit;
    end
  end

  assign a_lsb = sh_a[0];
  assign b_lsb = sh_b[0];

endmodule

// File: rtl/seradd_sequencer.sv
// Bit-serial WIDTH-bit adder controller driving a registered full-adder datapath.
// Define SERADD_CLK_GATE_EN to gate the datapath clock (adds the WAKE cycle).
module seradd_sequencer
  import seradd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = DEF_LAT
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Req,
  input  logic [WIDTH-1:0] Op_a,
  input  logic [WIDTH-1:0] Op_b,
  input  logic             Cin,
  output logic             Ack,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  input  logic             Test_mode,
  output logic             Fa_a,
  output logic             Fa_b,
  output logic             Fa_c,
  input  logic             Fa_sum,
  input  logic             Fa_carry,
  output logic             Cg_en,
  output logic             Scan_en
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t           state, state_next;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             accept, issue, sample, finish, last;
  logic             a_lsb, b_lsb;
  logic [WIDTH-1:0] acc;

  seradd_opshift #(.WIDTH(WIDTH), .IW(IW)) u_opshift (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .load    (accept),
    .shift   (sample),
    .op_a    (Op_a),
    .op_b    (Op_b),
    .a_lsb   (a_lsb),
    .b_lsb   (b_lsb),
    .wr_en   (sample),
    .wr_idx  (idx),
    .wr_bit  (Fa_sum),
    .acc     (acc)
  );

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = (idx == IW'(WIDTH - 1));
    issue      = !Test_mode && (state == ST_ISSUE);
    sample     = !Test_mode && (state == ST_SAMPLE);
    finish     = !Test_mode && (state == ST_DONE);
    if (Test_mode) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (Req) begin
          accept = 1'b1;
`ifdef SERADD_CLK_GATE_EN
          state_next = ST_WAKE;
`else
          state_next = ST_ISSUE;
`endif
        end
        ST_WAKE:   state_next = ST_ISSUE;
        ST_ISSUE:  state_next = (LAT > 1) ? ST_WAIT : ST_SAMPLE;
        ST_WAIT:   if (cnt == CW'(LAT - 1)) state_next = ST_SAMPLE;
        ST_SAMPLE: state_next = last ? ST_DONE : ST_ISSUE;
        ST_DONE:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      Ack     <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Result  <= '0;
      Cout    <= 1'b0;
      Fa_a    <= 1'b0;
      Fa_b    <= 1'b0;
      Fa_c    <= 1'b0;
      Scan_en <= 1'b0;
    end else begin
      state   <= state_next;
      Scan_en <= Test_mode;
      Ack     <= accept;
      Done    <= finish;
      // Busy stays high through the Done cycle itself.
      Busy    <= (state_next != ST_IDLE) || finish;
      if (accept) begin
        carry <= Cin;
        idx   <= '0;
      end
      if (issue) begin
        Fa_a <= a_lsb;
        Fa_b <= b_lsb;
        Fa_c <= carry;
        cnt  <= CW'(1);
      end
      if (state == ST_WAIT) cnt <= cnt + CW'(1);
      if (sample) begin
        carry <= Fa_carry;
        if (!last) idx <= idx + IW'(1);
      end
      if (finish) begin
        Result <= acc;
        Cout   <= carry;
      end
    end
  end

`ifdef SERADD_CLK_GATE_EN
  always_ff @(posedge Clock) begin
    if (!Reset_n) Cg_en <= 1'b0;
    else          Cg_en <= Test_mode || (state_next != ST_IDLE);
  end
`else
  assign Cg_en = 1'b1;
`endif

endmodule

// File: tb/tb_seradd_sequencer.sv
// Directed bench for seradd_sequencer with a behavioural registered full adder.
// Honors SERADD_CLK_GATE_EN for the expected latency and Cg_en idle level.
module tb_seradd_sequencer;

  localparam int WIDTH = 8;
  localparam int LAT   = 2;
`ifdef SERADD_CLK_GATE_EN
  localparam int DONE_AT = 26;
  localparam logic CG_IDLE = 1'b0;
`else
  localparam int DONE_AT = 25;
  localparam logic CG_IDLE = 1'b1;
`endif

  logic             Clock = 1'b0;
  logic             Reset_n, Req, Cin, Test_mode;
  logic [WIDTH-1:0] Op_a, Op_b, Result;
  logic             Ack, Busy, Done, Cout, Fa_a, Fa_b, Fa_c, Cg_en, Scan_en;
  logic             Fa_sum = 1'b0, Fa_carry = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  // Fa_* registered by the DUT plus one output register here: LAT=2 in total.
  always @(posedge Clock) begin
    Fa_sum   <= Fa_a ^ Fa_b ^ Fa_c;
    Fa_carry <= (Fa_a & Fa_b) | (Fa_a & Fa_c) | (Fa_b & Fa_c);
  end

  seradd_sequencer #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .Op_a(Op_a), .Op_b(Op_b),
    .Cin(Cin), .Ack(Ack), .Busy(Busy), .Done(Done), .Result(Result),
    .Cout(Cout), .Test_mode(Test_mode), .Fa_a(Fa_a), .Fa_b(Fa_b),
    .Fa_c(Fa_c), .Fa_sum(Fa_sum), .Fa_carry(Fa_carry), .Cg_en(Cg_en),
    .Scan_en(Scan_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Raises Req and returns how many cycles until Ack was seen (0 = never).
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input bit keep_req, output int waited);
    Op_a = a; Op_b = b; Cin = c; Req = 1'b1;
    waited = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clock);
      if (Ack) begin
        waited = k;
        break;
      end
    end
    if (!keep_req) Req = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] exp_res, input logic exp_cout,
                        input bit keep_req);
    int waited, n, extra;
    start_op(a, b, c, keep_req, waited);
    check({tag, "_ack"}, waited, 1);
    extra = 0;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge Clock);
      if (Ack) extra++;
      if (i == 5) begin
        check({tag, "_busy_mid"}, Busy, 1);
        check({tag, "_cg_mid"}, Cg_en, 1);
      end
      if (Done) begin
        n = i;
        break;
      end
    end
    check({tag, "_done_cyc"}, n, DONE_AT);
    check({tag, "_res"}, Result, exp_res);
    check({tag, "_cout"}, Cout, exp_cout);
    check({tag, "_busy_done"}, Busy, 1);
    check({tag, "_no_ack_busy"}, extra, 0);
  endtask

  initial begin
    int waited, dones, acks;
    Reset_n = 1'b0; Req = 1'b0; Cin = 1'b0; Test_mode = 1'b0;
    Op_a = '0; Op_b = '0;
    repeat (3) @(negedge Clock);
    check("rst_ack", Ack, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_res", {Cout, Result}, 0);
    check("rst_fa", {Fa_a, Fa_b, Fa_c}, 0);
    check("rst_scan", Scan_en, 0);
    check("rst_cg", Cg_en, CG_IDLE);
    Reset_n = 1'b1;
    @(negedge Clock);

    // Case 1 and 2: basic sums, carry-out overflow, carry-in only.
    run_op("c1", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b0);
    @(negedge Clock);
    check("c1_done_pulse", Done, 0);
    check("c1_cg_idle", Cg_en, CG_IDLE);
    run_op("c2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge Clock);
    run_op("c2b", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    @(negedge Clock);

    // Case 3: Req held through two back-to-back operations.
    run_op("c3a", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b1);
    run_op("c3b", 8'h80, 8'h81, 1'b0, 8'h01, 1'b1, 1'b1);
    Req = 1'b0;
    repeat (2) @(negedge Clock);

    // Case 4: reset pulse at cycle 10 of an operation.
    start_op(8'hA5, 8'h5A, 1'b1, 1'b0, waited);
    check("c4_ack", waited, 1);
    repeat (10) @(negedge Clock);
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    check("c4_busy", Busy, 0);
    check("c4_out", {Ack, Done, Cout, Result, Fa_a, Fa_b, Fa_c, Scan_en}, 0);
    check("c4_cg", Cg_en, CG_IDLE);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (Done) dones++;
    end
    check("c4_no_done", dones, 0);
    run_op("c4r", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b0);
    @(negedge Clock);

    // Case 5: Test_mode rises at cycle 12, then Req while in test mode.
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0, waited);
    check("c5_ack", waited, 1);
    repeat (12) @(negedge Clock);
    Test_mode = 1'b1;
    @(negedge Clock);
    check("c5_scan", Scan_en, 1);
    check("c5_cg", Cg_en, 1);
    check("c5_busy", Busy, 0);
    check("c5_res", {Cout, Result}, 9'h096);
    Req = 1'b1;
    acks = 0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      if (Ack) acks++;
      if (Done) dones++;
    end
    check("c5_tm_no_ack", acks, 0);
    Test_mode = 1'b0;
    Req = 1'b0;
    @(negedge Clock);
    check("c5_scan_off", Scan_en, 0);
    check("c5_cg_off", Cg_en, CG_IDLE);
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (Done) dones++;
    end
    check("c5_no_done", dones, 0);
    check("c5_res_hold", {Cout, Result}, 9'h096);
    run_op("c5r", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seradd_sequencer.md
Name: seradd_sequencer

Overview:
- Controller that sequences the registered full-adder datapath as a bit-serial WIDTH-bit adder.
- Accepts an operand pair through a Req/Ack handshake and feeds bits LSB first into Fa_a/Fa_b/Fa_c.
- Waits out the datapath's LAT-cycle register latency per bit and loops Fa_carry back as the next carry-in.
- Owns the datapath's Cg_en and Scan_en controls.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- LAT, 2, cycles from Fa_a/b/c valid to Fa_sum/Fa_carry valid (input reg + output reg).

Ports:
- Clock  input  1  system clock; all logic on rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- Req  input  1  operation request; operands valid while high.
- Op_a  input  WIDTH  operand A.
- Op_b  input  WIDTH  operand B.
- Cin  input  1  initial carry-in.
- Ack  output  1  1-cycle pulse when operands are latched.
- Busy  output  1  high from the accept cycle until Done inclusive.
- Done  output  1  1-cycle pulse when Result/Cout are valid.
- Result  output  WIDTH  sum; held until next accept.
- Cout  output  1  final carry; held until next accept.
- Test_mode  input  1  scan test request.
- Fa_a, Fa_b, Fa_c  output  1 each  datapath bit inputs (registered).
- Fa_sum, Fa_carry  input  1 each  datapath registered outputs.
- Cg_en  output  1  datapath clock-gate enable.
- Scan_en  output  1  datapath clock-mux select; equals registered Test_mode.

Behaviour:
- Reset (Reset_n=0 at an edge):
  - State IDLE.
  - Ack, Busy, Done, Result, Cout, Fa_a/b/c, Scan_en = 0.
  - Cg_en = 0.
  - Applies mid-operation too: the partial result is discarded and no Done is issued.
- All outputs are registered.
- States:
  - IDLE
  - WAKE
  - ISSUE
  - WAIT
  - SAMPLE
  - DONE
- IDLE:
  - Req=1 and Test_mode=0: latch Op_a, Op_b and Cin into shift and carry registers, pulse Ack, set Busy, Cg_en=1, go to WAKE.
  - Req is ignored in every other state; Ack is never issued while Busy.
- WAKE:
  - One cycle so the gated clock is running before the first bit.
  - Then ISSUE with bit index 0.
- ISSUE:
  - Drive Fa_a/Fa_b with operand bit [idx] and Fa_c with the carry register.
  - Load the wait counter with 1, go to WAIT.
- WAIT:
  - Hold Fa_* stable.
  - Increment the counter; when counter==LAT-1, go to SAMPLE.
  - For LAT=1, WAIT is skipped.
- SAMPLE (datapath outputs valid this cycle):
  - Result[idx] <= Fa_sum; carry <= Fa_carry.
  - If idx==WIDTH-1: Cout <= Fa_carry, go to DONE.
  - Else idx+1, go to ISSUE.
- DONE:
  - Pulse Done, clear Busy, Cg_en=0, go to IDLE.
  - A new Req is accepted the cycle after DONE, not in DONE.
- Latency:
  - Ack cycle = cycle 0.
  - Done asserts at cycle 2 + WIDTH*(LAT+1).
  - WIDTH=8, LAT=2: cycle 26.
- Arithmetic:
  - {Cout,Result} = Op_a + Op_b + Cin, modulo 2^(WIDTH+1).
  - Overflow is visible only through Cout.
- Test_mode:
  - Scan_en <= Test_mode every cycle.
  - While Test_mode=1: Cg_en=1 is forced, the FSM returns to IDLE next edge (abort, no Done), Busy=0, Result/Cout hold.
  - On Test_mode falling, the FSM stays IDLE and Cg_en returns to 0.
- Simultaneous Req and Test_mode rising in IDLE: Test_mode wins, no Ack.

Optional Feature:
- SERADD_CLK_GATE_EN defined:
  - Cg_en low in IDLE, high from accept through DONE.
  - The WAKE state is used, as described above.
- Undefined:
  - Cg_en tied to 1 and WAKE is removed (IDLE goes straight to ISSUE).
  - Done asserts at cycle 1 + WIDTH*(LAT+1), i.e. 25 for the defaults.

Decomposition:
- Package seradd_pkg:
  - State enum (IDLE, WAKE, ISSUE, WAIT, SAMPLE, DONE).
  - Default WIDTH/LAT constants.
  - Function giving the Done cycle from WIDTH/LAT.
- Sub-module seradd_opshift:
  - WIDTH-bit operand pair shift register with load/shift and LSB outputs.
  - Result assembly register with bit write at idx.
- The FSM, counters and handshake stay in seradd_sequencer.

Test Plan:
- Bench drives a behavioural LAT-cycle full-adder model on Fa_*.
- Case 1: Op_a=8'h3C, Op_b=8'h5A, Cin=0 -> Ack at cycle 0, Done at cycle 26, Result=8'h96, Cout=0.
- Case 2: Op_a=8'hFF, Op_b=8'h01, Cin=0 -> Result=8'h00, Cout=1; then Op_a=8'h00, Op_b=8'h00, Cin=1 -> Result=8'h01, Cout=0.
- Case 3: Req held high continuously through two operations -> exactly two Ack pulses; second Ack one cycle after the first Done; no Ack while Busy.
- Case 4: Reset_n=0 for one cycle at cycle 10 of an operation -> all outputs 0 next cycle, no Done; next Req is accepted normally.
- Case 5: Test_mode=1 at cycle 12 -> Scan_en=1 and Cg_en=1 next cycle, Busy=0, no Done, Result unchanged; Req with Test_mode=1 gets no Ack.
- Case 6: build without SERADD_CLK_GATE_EN -> Cg_en constant 1, Done at cycle 25 for case 1, same Result=8'h96.
